// File: rtl/field_packetizer.sv
// Captures decoder fields into a pixel FIFO and re-emits each as an Avalon-ST video
// control packet followed by a video data packet.
module field_packetizer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned FIELD_HEIGHT = 240,
  parameter int unsigned FIFO_DEPTH   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  vid_valid,
  input  logic                  vid_sof,
  input  logic                  vid_field,
  output logic [DATA_WIDTH-1:0] dout_data,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int unsigned PixTotal = WIDTH * FIELD_HEIGHT;
  localparam int unsigned CntW     = $clog2(PixTotal + 1);
  localparam int unsigned AddrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CntW-1:0] PixLast  = CntW'(PixTotal - 1);
  localparam logic [AddrW:0]  FifoFull = (AddrW + 1)'(FIFO_DEPTH);
  localparam logic [15:0]     Width16  = 16'(WIDTH);
  localparam logic [15:0]     Height16 = 16'(FIELD_HEIGHT);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCtrl   = 2'd1;
  localparam logic [1:0] StVhdr   = 2'd2;
  localparam logic [1:0] StPixels = 2'd3;

  // Capture side
  logic            cap_active_q, cap_active_d;
  logic [CntW-1:0] cap_cnt_q, cap_cnt_d, cap_base;
  logic            field_pending_q, field_pending_d;
  logic            cap_field_q, cap_field_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            sof_hit, cap_start, cap_drop, pix_in;

  // FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]        fifo_cnt_q, fifo_cnt_d;
  logic                  fifo_full, fifo_empty, fifo_wr, fifo_rd;

  // Output side
  logic [1:0]            state_q, state_d;
  logic [3:0]            hdr_cnt_q, hdr_cnt_d;
  logic [CntW-1:0]       pix_cnt_q, pix_cnt_d;
  logic                  out_field_q, out_field_d;
  logic                  dv_q, dv_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_WIDTH-1:0] dd_q, dd_d;
  logic                  load_ok, pend_take;
  logic [3:0]            hdr_nib;

  assign fifo_full  = (fifo_cnt_q == FifoFull);
  assign fifo_empty = (fifo_cnt_q == '0);

  always_comb begin
    sof_hit   = vid_valid && vid_sof && !cap_active_q;
    cap_start = sof_hit && !field_pending_q;
    cap_drop  = sof_hit && field_pending_q;
    pix_in    = cap_start || (cap_active_q && vid_valid);
    fifo_wr   = pix_in && !fifo_full;
    cap_base  = cap_start ? '0 : cap_cnt_q;

    cap_active_d    = cap_active_q;
    cap_cnt_d       = cap_cnt_q;
    cap_field_d     = cap_field_q;
    overflow_d      = overflow_q;
    drop_cnt_d      = drop_cnt_q;
    field_pending_d = field_pending_q;

    // A lost pixel still counts toward the field so the next SOF lines up.
    if (pix_in) begin
      if (cap_base == PixLast) begin
        cap_active_d = 1'b0;
        cap_cnt_d    = '0;
      end else begin
        cap_active_d = 1'b1;
        cap_cnt_d    = cap_base + 1'b1;
      end
      if (fifo_full) overflow_d = 1'b1;
    end
    if (cap_start) begin
      cap_field_d     = vid_field;
      field_pending_d = 1'b1;
    end else if (pend_take) begin
      field_pending_d = 1'b0;
    end
    if (cap_drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({fifo_wr, fifo_rd})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_comb begin
    case (hdr_cnt_q)
      4'd0:    hdr_nib = Width16[15:12];
      4'd1:    hdr_nib = Width16[11:8];
      4'd2:    hdr_nib = Width16[7:4];
      4'd3:    hdr_nib = Width16[3:0];
      4'd4:    hdr_nib = Height16[15:12];
      4'd5:    hdr_nib = Height16[11:8];
      4'd6:    hdr_nib = Height16[7:4];
      4'd7:    hdr_nib = Height16[3:0];
      4'd8:    hdr_nib = {1'b1, out_field_q, 2'b00};
      default: hdr_nib = 4'h0;
    endcase
  end

  // The single output register is refilled only when empty or being accepted.
  assign load_ok = !dv_q || dout_ready;

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    out_field_d = out_field_q;
    dv_d        = dv_q;
    dd_d        = dd_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    pend_take   = 1'b0;
    fifo_rd     = 1'b0;
    if (load_ok) begin
      dv_d  = 1'b0;
      dd_d  = '0;
      sop_d = 1'b0;
      eop_d = 1'b0;
      case (state_q)
        StIdle: begin
          if (field_pending_q) begin
            dv_d        = 1'b1;
            dd_d        = DATA_WIDTH'(8'h0F);
            sop_d       = 1'b1;
            pend_take   = 1'b1;
            out_field_d = cap_field_q;
            hdr_cnt_d   = '0;
            state_d     = StCtrl;
          end
        end
        StCtrl: begin
          dv_d = 1'b1;
          dd_d = DATA_WIDTH'(hdr_nib);
          if (hdr_cnt_q == 4'd8) begin
            eop_d   = 1'b1;
            state_d = StVhdr;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
          end
        end
        StVhdr: begin
          dv_d      = 1'b1;
          sop_d     = 1'b1;
          pix_cnt_d = '0;
          state_d   = StPixels;
        end
        default: begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            dv_d    = 1'b1;
            dd_d    = mem_q[rd_ptr_q];
            if (pix_cnt_q == PixLast) begin
              eop_d   = 1'b1;
              state_d = StIdle;
            end else begin
              pix_cnt_d = pix_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= vid_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_active_q    <= 1'b0;
      cap_cnt_q       <= '0;
      cap_field_q     <= 1'b0;
      field_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      drop_cnt_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
      state_q         <= StIdle;
      hdr_cnt_q       <= '0;
      pix_cnt_q       <= '0;
      out_field_q     <= 1'b0;
      dv_q            <= 1'b0;
      dd_q            <= '0;
      sop_q           <= 1'b0;
      eop_q           <= 1'b0;
    end else begin
      cap_active_q    <= cap_active_d;
      cap_cnt_q       <= cap_cnt_d;
      cap_field_q     <= cap_field_d;
      field_pending_q <= field_pending_d;
      overflow_q      <= overflow_d;
      drop_cnt_q      <= drop_cnt_d;
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_cnt_q      <= fifo_cnt_d;
      state_q         <= state_d;
      hdr_cnt_q       <= hdr_cnt_d;
      pix_cnt_q       <= pix_cnt_d;
      out_field_q     <= out_field_d;
      dv_q            <= dv_d;
      dd_q            <= dd_d;
      sop_q           <= sop_d;
      eop_q           <= eop_d;
    end
  end

  assign dout_data          = dd_q;
  assign dout_valid         = dv_q;
  assign dout_startofpacket = sop_q;
  assign dout_endofpacket   = eop_q;
  assign overflow           = overflow_q;
  assign drop_count         = drop_cnt_q;

endmodule

// File: tb/tb_field_packetizer.sv
// Directed bench for field_packetizer: a queue model of the expected beat stream is
// checked on every accepted beat, plus literal expectations for key scenarios.
module tb_field_packetizer;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int D    = 16;
  localparam int D2   = 4;
  localparam int NPIX = W * H;

  typedef logic [9:0] beat_t;  // {sop, eop, data}

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vid_data = '0;
  logic       vid_valid = 1'b0, vid_sof = 1'b0, vid_field = 1'b0, dout_ready = 1'b0;
  logic [7:0] dout_data, drop_count;
  logic       dout_valid, dout_startofpacket, dout_endofpacket, overflow;

  logic [7:0] v2_data = '0;
  logic       v2_valid = 1'b0, v2_sof = 1'b0, v2_field = 1'b0, ready2 = 1'b0;
  logic [7:0] d2_data, d2_drop;
  logic       d2_valid, d2_sop, d2_eop, d2_overflow;

  always #5 clock = ~clock;

  field_packetizer #(.DATA_WIDTH(8), .WIDTH(W), .FIELD_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .vid_data(vid_data), .vid_valid(vid_valid),
    .vid_sof(vid_sof), .vid_field(vid_field), .dout_data(dout_data),
    .dout_ready(dout_ready), .dout_valid(dout_valid),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .overflow(overflow), .drop_count(drop_count)
  );

  field_packetizer #(.DATA_WIDTH(8), .WIDTH(W), .FIELD_HEIGHT(H), .FIFO_DEPTH(D2)) dut2 (
    .clock(clock), .reset(reset), .vid_data(v2_data), .vid_valid(v2_valid),
    .vid_sof(v2_sof), .vid_field(v2_field), .dout_data(d2_data),
    .dout_ready(ready2), .dout_valid(d2_valid),
    .dout_startofpacket(d2_sop), .dout_endofpacket(d2_eop),
    .overflow(d2_overflow), .drop_count(d2_drop)
  );

  beat_t exp_q[$];
  beat_t got_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Expected packet pair for one field built from the packet format rules.
  function automatic void push_field(input logic f, input logic [7:0] base);
    exp_q.push_back(10'h20F);
    for (int k = 0; k < 4; k++) exp_q.push_back(beat_t'((W >> (12 - 4 * k)) & 15));
    for (int k = 0; k < 4; k++) exp_q.push_back(beat_t'((H >> (12 - 4 * k)) & 15));
    exp_q.push_back({2'b01, f ? 8'h0C : 8'h08});
    exp_q.push_back(10'h200);
    for (int i = 0; i < NPIX; i++) exp_q.push_back({1'b0, i == NPIX - 1, 8'(base + i)});
  endfunction

  always @(negedge clock) begin
    beat_t cur;
    cur = {dout_startofpacket, dout_endofpacket, dout_data};
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("hold_during_stall", cur, prev_beat);
      if (dout_valid && dout_ready) begin
        got_q.push_back(cur);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_beat: got %0h expected no beat", cur);
        end else begin
          check("beat", cur, exp_q.pop_front());
        end
      end
      prev_stall <= dout_valid && !dout_ready;
      prev_beat  <= cur;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_field(input logic f, input logic [7:0] base);
    for (int i = 0; i < NPIX; i++) begin
      vid_valid = 1'b1;
      vid_sof   = (i == 0);
      vid_field = f;
      vid_data  = 8'(base + i);
      @(posedge clock);
      #1;
    end
    vid_valid = 1'b0;
    vid_sof   = 1'b0;
  endtask

  // mode 1: ready held high, mode 2: ready toggles every cycle
  task automatic drain(input int mode, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      if (mode == 2) dout_ready = ~dout_ready;
      else dout_ready = 1'b1;
      @(posedge clock);
      #1;
      c++;
    end
    check("drain_complete_remaining", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_sop"}, dout_startofpacket, 0);
    check({tag, "_eop"}, dout_endofpacket, 0);
    check({tag, "_data"}, dout_data, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_drop_count"}, drop_count, 0);
  endtask

  initial begin
    beat_t lit [19];
    beat_t g;
    int    c;

    idle(3);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(2);
    check("post_reset_valid", dout_valid, 0);

    // F0 with pixels 1..8, ready high
    lit = '{10'h20F, 10'h000, 10'h000, 10'h000, 10'h004, 10'h000, 10'h000, 10'h000,
            10'h002, 10'h108, 10'h200, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005,
            10'h006, 10'h007, 10'h108};
    got_q.delete();
    dout_ready = 1'b1;
    push_field(1'b0, 8'd1);
    send_field(1'b0, 8'd1);
    drain(1, 200);
    check("f0_beat_count", got_q.size(), 19);
    for (int i = 0; i < 19; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 10'h3FF;
      check($sformatf("f0_literal_beat%0d", i), g, lit[i]);
    end
    check("f0_overflow", overflow, 0);

    // F1 with ready toggling
    got_q.delete();
    dout_ready = 1'b0;
    push_field(1'b1, 8'hA1);
    fork
      send_field(1'b1, 8'hA1);
      drain(2, 400);
    join
    check("f1_beat_count", got_q.size(), 19);
    g = (got_q.size() > 9) ? got_q[9] : 10'h3FF;
    check("f1_interlace_beat", g, 10'h10C);

    // Two fields buffered while output is stalled for 40 cycles
    dout_ready = 1'b0;
    push_field(1'b0, 8'h11);
    push_field(1'b1, 8'h21);
    send_field(1'b0, 8'h11);
    idle(2);
    send_field(1'b1, 8'h21);
    idle(40 - 2 * NPIX - 2);
    check("two_fields_overflow", overflow, 0);
    drain(1, 200);

    // Third SOF while a field is still pending is dropped
    dout_ready = 1'b0;
    push_field(1'b0, 8'h41);
    push_field(1'b1, 8'h61);
    send_field(1'b0, 8'h41);
    idle(2);
    send_field(1'b1, 8'h61);
    idle(2);
    send_field(1'b0, 8'h81);
    idle(2);
    check("drop_count_after_drop", drop_count, 1);
    drain(1, 300);
    idle(40);
    check("drop_count_sticky", drop_count, 1);

    // Reset in the middle of the pixel packet
    dout_ready = 1'b1;
    push_field(1'b0, 8'h31);
    send_field(1'b0, 8'h31);
    c = 0;
    while (!(dout_valid && dout_data == 8'h33) && c < 60) begin
      @(posedge clock);
      #1;
      c++;
    end
    check("reached_pixel3", {dout_valid, dout_data}, {1'b1, 8'h33});
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    check_outputs_zero("mid_packet_reset");
    reset = 1'b0;
    idle(2);
    got_q.delete();
    push_field(1'b0, 8'h51);
    send_field(1'b0, 8'h51);
    drain(1, 200);
    check("after_reset_beat_count", got_q.size(), 19);
    g = (got_q.size() > 0) ? got_q[0] : 10'h3FF;
    check("after_reset_first_beat", g, 10'h20F);

    // Depth-4 instance: overflow on the fifth write, sticky until reset
    for (int i = 0; i < NPIX; i++) begin
      v2_valid = 1'b1;
      v2_sof   = (i == 0);
      v2_data  = 8'(i);
      @(posedge clock);
      #1;
      check($sformatf("small_fifo_overflow_after_write%0d", i + 1), d2_overflow, i >= D2);
    end
    v2_valid = 1'b0;
    v2_sof   = 1'b0;
    idle(5);
    check("small_fifo_overflow_sticky", d2_overflow, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("small_fifo_overflow_reset", d2_overflow, 0);
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/field_packetizer.md
FIELD_PACKETIZER -- requirements
Module: field_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter WIDTH, default 640, active pixels per line.
REQ-003 SHALL have parameter FIELD_HEIGHT, default 240, lines per field.
REQ-004 SHALL have parameter FIFO_DEPTH, default 1024, pixel buffer depth, power of two.
REQ-005 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port vid_data  in  DATA_WIDTH  raw pixel from decoder.
REQ-008 SHALL have port vid_valid  in  1  vid_data valid this cycle; cannot be stalled.
REQ-009 SHALL have port vid_sof  in  1  qualifies first pixel of a field.
REQ-010 SHALL have port vid_field  in  1  field id at vid_sof (0 = F0, 1 = F1).
REQ-011 SHALL have port dout_data  out  DATA_WIDTH  Avalon-ST video source data.
REQ-012 SHALL have port dout_ready  in  1  downstream ready.
REQ-013 SHALL have port dout_valid  out  1  dout_data valid.
REQ-014 SHALL have port dout_startofpacket  out  1  first beat of packet.
REQ-015 SHALL have port dout_endofpacket  out  1  last beat of packet.
REQ-016 SHALL have port overflow  out  1  sticky: pixel lost to full buffer.
REQ-017 SHALL have port drop_count  out  8  saturating count of rejected fields.

Function
REQ-018 Capture side SHALL start a field on vid_valid && vid_sof when not capturing and field_pending is clear; latch vid_field; set field_pending; write that pixel.
REQ-019 While capturing, every vid_valid beat SHALL be written to the FIFO; capture ends after the WIDTH*FIELD_HEIGHT-th pixel; vid_valid outside capture SHALL be ignored.
REQ-020 vid_sof while capturing SHALL be treated as an ordinary pixel (no restart).
REQ-021 vid_valid && vid_sof while not capturing and field_pending set SHALL drop the field, incrementing drop_count (saturate at 255).
REQ-022 Write with FIFO full SHALL discard the pixel, still advance the capture count, and set overflow.
REQ-023 Simultaneous FIFO write and read SHALL both occur; occupancy unchanged.
REQ-024 Output FSM states: IDLE, CTRL, VHDR, PIXELS.
REQ-025 IDLE: when field_pending, present beat 0x0F with SOP, clear field_pending, go CTRL.
REQ-026 CTRL: 9 further beats, low nibble carrying WIDTH[15:12], [11:8], [7:4], [3:0], FIELD_HEIGHT[15:12]..[3:0], then interlace nibble 4'b1000 (F0) or 4'b1100 (F1), upper bits zero; EOP on the ninth; then VHDR.
REQ-027 VHDR: one beat 0x00 with SOP; then PIXELS.
REQ-028 PIXELS: beats from FIFO in order, WIDTH*FIELD_HEIGHT beats; dout_valid low while FIFO empty; EOP on last pixel; then IDLE.
REQ-029 A beat SHALL transfer only on a cycle with dout_valid && dout_ready; while dout_valid && !dout_ready, dout_data/SOP/EOP SHALL hold.
REQ-030 Only one beat in flight; IDLE-to-first-beat latency 1 cycle; FIFO-nonempty-to-pixel latency at most 2 cycles.
REQ-031 Capture of field N+1 SHALL proceed while output still drains field N; pixels stay ordered.
REQ-032 Header data and SOP/EOP SHALL be zero-extended/deasserted on all other beats.

Reset
REQ-033 reset SHALL force: FSM IDLE, capture idle, field_pending 0, FIFO empty, dout_valid/SOP/EOP 0, dout_data 0, overflow 0, drop_count 0.
REQ-034 reset mid-packet SHALL abandon it; no EOP emitted; next field starts with a fresh control packet.

Verification (WIDTH=4, FIELD_HEIGHT=2, FIFO_DEPTH=16)
REQ-035 F0 field, pixels 1..8, dout_ready=1 -> beats 0x0F(SOP),0,0,0,4,0,0,0,2,0x08(EOP),0x00(SOP),1..8 with EOP on 8.
REQ-036 F1 field, dout_ready toggling every cycle -> same stream, interlace beat 0x0C, data stable during stalls, no duplicated or lost beats.
REQ-037 dout_ready=0 for 40 cycles while field of 8 pixels plus second field of 8 captured -> overflow 0 (16 fit); both packets emitted in order after release.
REQ-038 FIFO_DEPTH=4, dout_ready=0, 8 pixels -> overflow=1 after fifth write; remains 1 until reset.
REQ-039 second vid_sof while first field not yet started (dout_ready=0 held, field_pending=1) -> drop_count=1, no extra packet.
REQ-040 reset asserted during PIXELS beat 3 -> next cycle all outputs 0; subsequent field yields complete correct packets.
